// File: rtl/add16_seq_ctrl.sv
// 16-bit sequential adder: one shared 4-bit carry-lookahead adder processes
// one nibble per clock, LSB first; results appear atomically on completion.

module cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pg
      assign p[gi] = x[gi] ^ y[gi];
      assign g[gi] = x[gi] & y[gi];
    end
  endgenerate

  // Carries are flattened lookahead terms rather than a ripple chain.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  generate
    for (gi = 0; gi < 4; gi++) begin : g_sum
      assign sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  assign cout = c[4];
endmodule

module add16_seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic        busy,
  output logic        done,
  output logic [15:0] s,
  output logic        co,
  output logic        ovf
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [11:0] shadow_reg;
  logic [1:0]  cnt_reg;
  logic        carry_reg;
  logic [15:0] s_reg;
  logic        co_reg;
  logic        ovf_reg;

  logic [3:0]  a_nibs [4];
  logic [3:0]  b_nibs [4];
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [3:0]  nib_sum;
  logic        nib_co;
  logic [15:0] full_sum;
  logic        full_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign a_nibs[gi] = a_reg[4*gi +: 4];
      assign b_nibs[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  assign nib_a = a_nibs[cnt_reg];
  assign nib_b = b_nibs[cnt_reg];

  cla4 u_cla4 (
    .x    (nib_a),
    .y    (nib_b),
    .cin  (carry_reg),
    .sum  (nib_sum),
    .cout (nib_co)
  );

  // The top nibble is never parked in the shadow; it goes straight to s.
  assign full_sum = {nib_sum, shadow_reg};
  assign full_ovf = (a_reg[15] == b_reg[15]) && (full_sum[15] != a_reg[15]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      a_reg      <= 16'h0000;
      b_reg      <= 16'h0000;
      shadow_reg <= 12'h000;
      cnt_reg    <= 2'd0;
      carry_reg  <= 1'b0;
      s_reg      <= 16'h0000;
      co_reg     <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= ci;
            cnt_reg   <= 2'd0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < 3; i++) begin
            if (cnt_reg == 2'(i)) shadow_reg[4*i +: 4] <= nib_sum;
          end
          carry_reg <= nib_co;
          cnt_reg   <= cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            s_reg     <= full_sum;
            co_reg    <= nib_co;
            ovf_reg   <= full_ovf;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg == RUN) || (state_reg == DONE);
  assign done = (state_reg == DONE);
  assign s    = s_reg;
  assign co   = co_reg;
  assign ovf  = ovf_reg;
endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Bench for add16_seq_ctrl: directed corner cases plus random operands checked
// against a plain-arithmetic model of a + b + ci.

module tb_add16_seq_ctrl;
  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        co;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  logic [15:0] last_s   = 16'h0000;
  logic        last_co  = 1'b0;
  logic        last_ovf = 1'b0;

  add16_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction: accept, optional ignored start pulse mid-run, completion.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic op_ci, input int junk_at);
    logic [16:0] full;
    logic        exp_ovf;
    int          cyc;
    int          busy_cnt;
    full    = {1'b0, op_a} + {1'b0, op_b} + {16'h0000, op_ci};
    exp_ovf = (op_a[15] == op_b[15]) && (full[15] != op_a[15]);
    a = op_a; b = op_b; ci = op_ci; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
    check_val("busy_after_accept", busy, 1);
    cyc = 0;
    busy_cnt = 1;
    while (!done && cyc < 10) begin
      if (cyc == junk_at) begin
        start = 1'b1; a = 16'hAAAA; b = 16'h5555;
      end else begin
        start = 1'b0;
      end
      check_val("s_hold", s, last_s);
      tick();
      cyc++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    check_val("latency", cyc, 4);
    check_val("s", s, full[15:0]);
    check_val("co", co, full[16]);
    check_val("ovf", ovf, exp_ovf);
    tick();
    check_val("done_width", done, 0);
    check_val("busy_end", busy, 0);
    check_val("busy_cycles", busy_cnt, 5);
    $display("[TB] a=%04h b=%04h ci=%0d -> s=%04h co=%0d ovf=%0d", op_a, op_b, op_ci, s, co, ovf);
    last_s = full[15:0]; last_co = full[16]; last_ovf = exp_ovf;
  endtask

  initial begin
    int t1;
    int t2;
    int bound;
    reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; ci = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_val("rst_s", s, 16'h0000);
    check_val("rst_co", co, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);

    run_op(16'h00FF, 16'h0001, 1'b0, -1);
    run_op(16'hFFFF, 16'h0001, 1'b0, -1);
    run_op(16'h1234, 16'h4321, 1'b1, -1);
    run_op(16'h7FFF, 16'h0001, 1'b0, -1);
    run_op(16'h8000, 16'h8000, 1'b0, -1);
    run_op(16'h0001, 16'h0001, 1'b0, 1);

    // Start held high: accepts every 6 cycles with the same operands.
    a = 16'h0003; b = 16'h0004; ci = 1'b0; start = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      tick();
      if (done) begin
        if (t1 < 0) t1 = cyc_cnt;
        else        t2 = cyc_cnt;
        check_val("held_s", s, 16'h0007);
      end
    end
    start = 1'b0;
    check_val("held_spacing", t2 - t1, 6);
    tick();
    check_val("held_idle", busy, 0);
    $display("[TB] held start: done at cycles %0d and %0d", t1, t2);
    last_s = 16'h0007; last_co = 1'b0; last_ovf = 1'b0;

    // Reset two cycles into RUN abandons the operation.
    a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_s", s, 16'h0000);
    check_val("midrst_co", co, 0);
    check_val("midrst_ovf", ovf, 0);
    bound = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) bound++;
    end
    check_val("midrst_no_done", bound, 0);
    $display("[TB] reset mid-run abandoned operation");
    last_s = 16'h0000; last_co = 1'b0; last_ovf = 1'b0;
    run_op(16'h0F0F, 16'h00F1, 1'b0, -1);

    for (int k = 0; k < 40; k++) begin
      int gap;
      run_op(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 2 : -1);
      gap = int'($urandom_range(0, 3));
      for (int j = 0; j < gap; j++) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
